// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state
// encoding and the architectural register-index width.
package hazard_ctrl_pkg;

   localparam int REG_IDX_W = 5;

   typedef enum logic [1:0] {
      ST_RUN  = 2'd0,
      ST_WAIT = 2'd1,
      ST_ERR  = 2'd2
   } hz_state_t;

endpackage : hazard_ctrl_pkg

// File: rtl/sat_counter.sv
// Saturating up-counter used for the performance counters. Once it
// reaches all-ones it holds there until reset instead of wrapping.
module sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         inc,
   output logic [W-1:0] count
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   // Next value: increment only while below the all-ones ceiling.
   always_comb begin
      count_d = count_q;
      if (inc && (count_q != '1)) begin
         count_d = count_q + W'(1);
      end
   end

   // Counter register, cleared asynchronously.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule : sat_counter

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller. Covers the hazards the forwarding
// unit cannot: load-use bubbles, EX-stage mispredict flushes and
// variable-latency data-memory waits (with a timeout that latches a
// sticky error). Stage enables are decoded combinationally from the
// current hazard terms; the wait FSM and perf counters are registered.
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int CNT_W   = 32,
   parameter int TIMEOUT = 64
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [REG_IDX_W-1:0] id_rs1,
   input  logic [REG_IDX_W-1:0] id_rs2,
   input  logic                 id_use_rs1,
   input  logic                 id_use_rs2,
   input  logic [REG_IDX_W-1:0] ex_rd,
   input  logic                 ex_memread,
   input  logic                 ex_mispredict,
   input  logic                 mem_req,
   input  logic                 mem_ready,
   output logic                 pc_write,
   output logic                 ifid_write,
   output logic                 idex_write,
   output logic                 exmem_write,
   output logic                 memwb_write,
   output logic                 ifid_flush,
   output logic                 idex_flush,
   output logic                 mem_err,
   output logic [CNT_W-1:0]     stall_cycles,
   output logic [CNT_W-1:0]     flush_events
);

   // wait_cnt must be able to hold TIMEOUT-1.
   localparam int WCNT_W = $clog2(TIMEOUT + 1);

   hz_state_t         state_q;
   logic [WCNT_W-1:0] wait_cnt_q;
   logic              mem_err_q;

   logic freeze;
   logic loaduse;
   logic in_err;
   logic stall_inc;
   logic flush_inc;

   assign freeze  = mem_req & ~mem_ready;
   assign loaduse = ex_memread & (ex_rd != '0)
                  & ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));
   assign in_err  = (state_q == ST_ERR);

   // Stage enables, priority ERR > freeze > mispredict > loaduse > normal.
   // A mispredict or load-use seen during a freeze is simply re-evaluated
   // on the cycle mem_ready rises, since the inputs are held by the frozen pipe.
   always_comb begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
      exmem_write = 1'b0;
      memwb_write = 1'b0;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      if (!reset_n || in_err || freeze) begin
         // everything held, no bubbles
      end else if (ex_mispredict) begin
         // ID instruction is squashed, so any load-use on it is moot
         pc_write    = 1'b1;
         ifid_write  = 1'b1;
         idex_write  = 1'b1;
         exmem_write = 1'b1;
         memwb_write = 1'b1;
         ifid_flush  = 1'b1;
         idex_flush  = 1'b1;
      end else if (loaduse) begin
         exmem_write = 1'b1;
         memwb_write = 1'b1;
         idex_flush  = 1'b1;
         idex_write  = 1'b1;
      end else begin
         pc_write    = 1'b1;
         ifid_write  = 1'b1;
         idex_write  = 1'b1;
         exmem_write = 1'b1;
         memwb_write = 1'b1;
      end
   end

   // Memory-wait FSM: counts consecutive frozen cycles, latches the error on timeout.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_RUN;
         wait_cnt_q <= '0;
         mem_err_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_RUN: begin
               if (freeze) begin
                  state_q    <= ST_WAIT;
                  wait_cnt_q <= WCNT_W'(1);
               end
            end
            ST_WAIT: begin
               if (freeze) begin
                  if (wait_cnt_q == WCNT_W'(TIMEOUT - 1)) begin
                     state_q    <= ST_ERR;
                     wait_cnt_q <= '0;
                     mem_err_q  <= 1'b1;
                  end else begin
                     wait_cnt_q <= wait_cnt_q + WCNT_W'(1);
                  end
               end else begin
                  // completed (mem_ready) or cancelled (mem_req dropped)
                  state_q    <= ST_RUN;
                  wait_cnt_q <= '0;
               end
            end
            ST_ERR: begin
               state_q <= ST_ERR;
            end
            default: begin
               state_q    <= ST_RUN;
               wait_cnt_q <= '0;
            end
         endcase
      end
   end

   assign mem_err = mem_err_q;

   // A stall cycle is one the pipe actually spends frozen or bubbling;
   // once in ERR the pipe is halted rather than stalled, so nothing counts.
   assign stall_inc = ~in_err & (freeze | (loaduse & ~ex_mispredict));
   assign flush_inc = ~in_err & ~freeze & ex_mispredict;

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk     (clk),
      .reset_n (reset_n),
      .inc     (stall_inc),
      .count   (stall_cycles)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk     (clk),
      .reset_n (reset_n),
      .inc     (flush_inc),
      .count   (flush_events)
   );

endmodule : hazard_ctrl
